mem_access_unit: RTL and testbench

Multicycle memory access unit between the multicycle control FSM and a handshaked backing memory. It turns the control unit's level-held `mem_read`/`mem_write`/`i_or_d` commands into single memory transactions. The next-address source is the PC for instruction fetches and the ALU output for data accesses. It captures fetched instructions into IR and loaded data into MDR, and pulses `mem_done` so the control FSM advances only after memory completes.

---
 rtl/mem_unit_pkg.sv | 20 ++
 rtl/mem_timeout_ctr.sv | 26 ++
 rtl/mem_access_unit.sv | 119 +++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_unit_pkg.sv
// Shared types and constants for the multicycle memory access unit.
package mem_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RDWR     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Response timeout counter: counts cycles spent waiting and flags expiry at TIMEOUT.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(TIMEOUT));

endmodule

// File: rtl/mem_access_unit.sv
// Turns level-held read/write commands from the control FSM into single
// handshaked memory transactions, capturing results into IR or MDR.
module mem_access_unit
    import mem_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              i_or_d,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] write_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              mem_done,
    output logic [1:0]        mem_err
);

    state_t            state;
    logic [1:0]        kind;
    logic [DATA_W-1:0] cmd_addr;
    logic              expired;

    assign cmd_addr = i_or_d ? alu_out : pc;

    // The counter restarts on the accept edge so WAIT always begins at zero.
    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == REQ && mem_req_ready),
        .enable  (state == WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            kind          <= FETCH;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            ir            <= '0;
            mdr           <= '0;
            busy          <= 1'b0;
            mem_done      <= 1'b0;
            mem_err       <= ERR_NONE;
        end else begin
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        mem_req_addr  <= cmd_addr;
                        mem_req_we    <= mem_write;
                        mem_req_wdata <= write_data;
                        kind          <= mem_write ? STORE : (i_or_d ? LOAD : FETCH);
                        busy          <= 1'b1;
                        // Illegal commands skip the memory entirely and report at once.
                        if (mem_read && mem_write) begin
                            state    <= DONE;
                            mem_err  <= ERR_RDWR;
                            mem_done <= 1'b1;
                        end else if (cmd_addr[1:0] != 2'b00) begin
                            state    <= DONE;
                            mem_err  <= ERR_MISALIGN;
                            mem_done <= 1'b1;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (kind == FETCH) begin
                            ir <= mem_resp_rdata;
                        end else if (kind == LOAD) begin
                            mdr <= mem_resp_rdata;
                        end
                        state    <= DONE;
                        mem_err  <= ERR_NONE;
                        mem_done <= 1'b1;
                    end else if (expired) begin
                        state    <= DONE;
                        mem_err  <= ERR_TIMEOUT;
                        mem_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a cycle-count reference model.
module tb_mem_access_unit;

    localparam int TO = 15;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        busy;
    logic        mem_done;
    logic [1:0]  mem_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expIr  = 32'd0;
    logic [31:0] expMdr = 32'd0;

    mem_access_unit #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .i_or_d         (i_or_d),
        .pc             (pc),
        .alu_out        (alu_out),
        .write_data     (write_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .ir             (ir),
        .mdr            (mdr),
        .busy           (busy),
        .mem_done       (mem_done),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One command from issue to completion. respDelay counts WAIT cycles before
    // the response; a negative value means memory never answers.
    task automatic applyStimulus(input logic rd, input logic wr, input logic iod,
                                 input logic [31:0] pcv, input logic [31:0] aluv,
                                 input logic [31:0] wd, input logic [31:0] rdata,
                                 input int readyDelay, input int respDelay);
        logic [31:0] addr;
        logic [1:0]  expErr;
        logic        illegal;
        int          acceptCycle, respCycle, doneCycle;
        logic        gotDone;

        addr        = iod ? aluv : pcv;
        illegal     = 1'b1;
        expErr      = 2'd0;
        acceptCycle = 1 + readyDelay;
        respCycle   = -1;
        if (rd && wr) begin
            expErr = 2'd2;
        end else if (addr[1:0] != 2'b00) begin
            expErr = 2'd1;
        end else begin
            illegal = 1'b0;
        end

        if (illegal) begin
            doneCycle = 1;
        end else if (respDelay >= 0 && respDelay <= TO) begin
            respCycle = acceptCycle + 1 + respDelay;
            doneCycle = respCycle + 1;
        end else begin
            doneCycle = acceptCycle + 1 + TO + 1;
        end

        @(negedge clk);
        mem_read       = rd;
        mem_write      = wr;
        i_or_d         = iod;
        pc             = pcv;
        alu_out        = aluv;
        write_data     = wd;
        mem_resp_rdata = rdata;
        @(posedge clk);

        gotDone = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            checkOutput("req_valid", 32'(mem_req_valid), 32'(!illegal && c <= acceptCycle));
            if (!illegal && c <= acceptCycle) begin
                checkOutput("req_addr", mem_req_addr, addr);
                checkOutput("req_we", 32'(mem_req_we), 32'(wr));
                checkOutput("req_wdata", mem_req_wdata, wd);
            end
            checkOutput("busy", 32'(busy), 32'(c <= doneCycle));
            checkOutput("mem_done", 32'(mem_done), 32'(c == doneCycle));
            if (c == doneCycle) begin
                if (expErr == 2'd0 && respCycle < 0) expErr = 2'd3;
                if (expErr == 2'd0 && rd && !iod) expIr  = rdata;
                if (expErr == 2'd0 && rd &&  iod) expMdr = rdata;
                checkOutput("mem_err", 32'(mem_err), 32'(expErr));
            end
            checkOutput("ir", ir, expIr);
            checkOutput("mdr", mdr, expMdr);
            if (c == doneCycle) begin
                mem_read       = 1'b0;
                mem_write      = 1'b0;
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                gotDone        = 1'b1;
                break;
            end
            mem_req_ready  = (!illegal && c == acceptCycle);
            mem_resp_valid = (c == respCycle);
        end
        if (!gotDone) checkOutput("done_bound", 32'd0, 32'd1);

        @(negedge clk);
        checkOutput("idle_after", {30'd0, busy, mem_done}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        int          k;
        logic        rd, wr, iod;
        logic [31:0] a;

        reset          = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        i_or_d         = 1'b0;
        pc             = 32'd0;
        alu_out        = 32'd0;
        write_data     = 32'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'd0;

        repeat (2) @(negedge clk);
        checkOutput("rst_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(mem_done), 32'd0);
        checkOutput("rst_err", 32'(mem_err), 32'd0);
        checkOutput("rst_ir", ir, 32'd0);
        checkOutput("rst_mdr", mdr, 32'd0);
        checkOutput("rst_addr", mem_req_addr, 32'd0);
        reset = 1'b1;

        // Directed scenarios
        applyStimulus(1, 0, 0, 32'h100, 32'h0, 32'h0, 32'h00500093, 0, 0);
        applyStimulus(1, 0, 1, 32'h104, 32'h204, 32'h0, 32'hDEADBEEF, 2, 0);
        applyStimulus(0, 1, 1, 32'h108, 32'h208, 32'h12345678, 32'hCAFEF00D, 0, 1);
        applyStimulus(1, 0, 1, 32'h10C, 32'h206, 32'h0, 32'h11111111, 0, 0);
        applyStimulus(1, 1, 1, 32'h110, 32'h20C, 32'h55AA55AA, 32'h22222222, 0, 0);
        applyStimulus(1, 0, 0, 32'h114, 32'h0, 32'h0, 32'h33333333, 1, -1);

        // Late response after the timeout must be ignored
        @(negedge clk);
        mem_resp_rdata = 32'hBADBAD00;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checkOutput("late_done", 32'(mem_done), 32'd0);
        checkOutput("late_ir", ir, expIr);
        @(negedge clk);
        checkOutput("late_ir2", ir, expIr);

        // Reset in the middle of WAIT aborts immediately
        @(negedge clk);
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        alu_out    = 32'h300;
        write_data = 32'h0F0F0F0F;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        mem_write = 1'b0;
        i_or_d    = 1'b0;
        #1;
        expIr  = 32'd0;
        expMdr = 32'd0;
        checkOutput("abort_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("abort_we", 32'(mem_req_we), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(mem_done), 32'd0);
        checkOutput("abort_ir", ir, 32'd0);
        checkOutput("abort_mdr", mdr, 32'd0);
        checkOutput("abort_addr", mem_req_addr, 32'd0);
        checkOutput("abort_wdata", mem_req_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mem_resp_rdata = 32'h77777777;
        mem_resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            checkOutput("post_rst_done", 32'(mem_done), 32'd0);
            checkOutput("post_rst_ir", ir, 32'd0);
        end

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            k   = $urandom_range(0, 15);
            iod = 1'($urandom_range(0, 1));
            if (k == 0) begin
                rd = 1'b1; wr = 1'b1;
            end else if (k <= 5) begin
                rd = 1'b1; wr = 1'b0; iod = 1'b0;
            end else if (k <= 10) begin
                rd = 1'b1; wr = 1'b0; iod = 1'b1;
            end else begin
                rd = 1'b0; wr = 1'b1;
            end
            r = $urandom();
            a = r & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            r = $urandom();
            applyStimulus(rd, wr, iod,
                          iod ? r & 32'hFFFF_FFFC : a, iod ? a : r,
                          $urandom(), $urandom(),
                          $urandom_range(0, 3),
                          ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
